// File: rtl/ts4231_pkg.sv
// Shared definitions for the TS4231 configuration path: sequencer state encoding
// and the default 12 MHz timing constants also used by ts4231_configurator.
package ts4231_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_START,
        ST_WAIT,
        ST_BACKOFF,
        ST_FINISH
    } seq_state_t;

    // 100 ms and 1 ms at 12 MHz
    localparam int unsigned CFG_TIMEOUT_CYCLES = 1200000;
    localparam int unsigned CFG_BACKOFF_CYCLES = 12000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ts4231_config_sequencer_cycle_timer.sv
// Up-counter with synchronous clear and a terminal-count compare; one instance
// is time-shared between the attempt timeout and the retry backoff gap.
module cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == term);

endmodule

// File: rtl/ts4231_config_sequencer.sv
// Walks every enabled TS4231 sensor through the shared configurator, with
// per-attempt timeout, bounded retries and a backoff gap between attempts.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for go; outputs hold the result of the last pass
//   SCAN    | look at sensor idx: skip if disabled, finish if past the end
//   START   | configurator launch (cfg_start is registered out of here)
//   WAIT    | timing the attempt until cfg_done or timeout
//   BACKOFF | idle gap after a failed attempt before retrying
//   FINISH  | end of pass; seq_done pulses, seq_busy drops
module ts4231_config_sequencer
    import ts4231_pkg::*;
#(
    parameter  int unsigned NUM_SENSORS    = 4,
    parameter  int unsigned MAX_RETRIES    = 3,
    parameter  int unsigned TIMEOUT_CYCLES = CFG_TIMEOUT_CYCLES,
    parameter  int unsigned BACKOFF_CYCLES = CFG_BACKOFF_CYCLES,
    localparam int unsigned SEL_W          = max_u(1, $clog2(NUM_SENSORS))
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [NUM_SENSORS-1:0] sensor_en,
    output logic                   cfg_start,
    output logic [SEL_W-1:0]       cfg_sel,
    input  logic                   cfg_done,
    input  logic                   cfg_ok,
    output logic [NUM_SENSORS-1:0] sensor_ready,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   seq_error
);

    localparam int unsigned TMR_W =
        max_u(1, max_u($clog2(TIMEOUT_CYCLES + 1), $clog2(BACKOFF_CYCLES + 1)));
    localparam logic [TMR_W-1:0] TO_TERM   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] BO_TERM   = TMR_W'((BACKOFF_CYCLES > 0) ? BACKOFF_CYCLES - 1 : 0);
    localparam logic [SEL_W:0]   IDX_END   = (SEL_W + 1)'(NUM_SENSORS);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    seq_state_t             state, state_nxt;
    logic [NUM_SENSORS-1:0] en_q;
    logic [SEL_W:0]         idx;
    logic [SEL_W-1:0]       idx_lo;
    logic [3:0]             retry;

    logic             scan_end, scan_hit;
    logic             wait_ok, wait_fail, can_retry;
    logic             tmr_load, tmr_en, tmr_expired;
    logic [TMR_W-1:0] tmr_term;
    logic             cfg_start_d, seq_done_d;

    assign idx_lo    = idx[SEL_W-1:0];
    assign scan_end  = (idx == IDX_END);
    assign scan_hit  = !scan_end && en_q[idx_lo];
    assign can_retry = (retry < RETRY_MAX);
    // A cfg_done arriving on the timeout cycle takes precedence over the timeout.
    assign wait_ok   = (state == ST_WAIT) && cfg_done && cfg_ok;
    assign wait_fail = (state == ST_WAIT) && (cfg_done ? !cfg_ok : tmr_expired);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (go) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (scan_end)      state_nxt = ST_FINISH;
                else if (scan_hit) state_nxt = ST_START;
            end
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wait_ok)        state_nxt = ST_SCAN;
                else if (wait_fail) state_nxt = can_retry ? ST_BACKOFF : ST_SCAN;
            end
            ST_BACKOFF: begin
                if (tmr_expired) state_nxt = ST_START;
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_start_d = (state == ST_START);
        seq_done_d  = (state == ST_FINISH);
        tmr_load    = (state == ST_START) || (wait_fail && can_retry);
        tmr_en      = (state == ST_WAIT) || (state == ST_BACKOFF);
        tmr_term    = (state == ST_BACKOFF) ? BO_TERM : TO_TERM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_start    <= 1'b0;
            cfg_sel      <= '0;
            sensor_ready <= '0;
            seq_busy     <= 1'b0;
            seq_done     <= 1'b0;
            seq_error    <= 1'b0;
            en_q         <= '0;
            idx          <= '0;
            retry        <= '0;
        end else begin
            cfg_start <= cfg_start_d;
            seq_done  <= seq_done_d;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        en_q         <= sensor_en;
                        sensor_ready <= '0;
                        seq_error    <= 1'b0;
                        idx          <= '0;
                        seq_busy     <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (scan_hit) begin
                        retry   <= '0;
                        cfg_sel <= idx_lo;
                    end else if (!scan_end) begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_ok) begin
                        sensor_ready[idx_lo] <= 1'b1;
                        idx                  <= idx + 1'b1;
                    end else if (wait_fail) begin
                        if (can_retry) begin
                            retry <= retry + 1'b1;
                        end else begin
                            seq_error <= 1'b1;
                            idx       <= idx + 1'b1;
                        end
                    end
                end
                ST_FINISH: seq_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    cycle_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .en     (tmr_en),
        .term   (tmr_term),
        .expired(tmr_expired)
    );

endmodule
